// File: rtl/rc_pulse_gen_pkg.sv
// Shared command-word layout, opcode constants and helpers for the RC pulse generator
// and the remote-control receive path that produces its command words.
package rc_pulse_gen_pkg;

    localparam logic [3:0] OP_ENABLE = 4'hF;
    localparam int         US_W      = 12;

    typedef struct packed {
        logic [3:0]      op;
        logic [7:0]      rsvd;
        logic [US_W-1:0] arg;
    } cmd_t;

    // Bits needed to hold 0..terminal-1 (never less than one bit).
    function automatic int cnt_w(input int terminal);
        return (terminal < 2) ? 1 : $clog2(terminal);
    endfunction

    // Zero keeps a channel silent; anything else is forced into [lo, hi].
    function automatic logic [US_W-1:0] clamp_us(input logic [US_W-1:0] raw,
                                                 input logic [US_W-1:0] lo,
                                                 input logic [US_W-1:0] hi);
        if (raw == '0)     return '0;
        else if (raw < lo) return lo;
        else if (raw > hi) return hi;
        else               return raw;
    endfunction

endpackage

// File: rtl/rc_pulse_gen_us_tick.sv
// Free-running prescaler: one-clk tick every CLK_DIV clocks, first tick CLK_DIV-1 clks after reset.
module rc_pulse_gen_us_tick
    import rc_pulse_gen_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);
    localparam int            PW   = cnt_w(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_cnt <= '0;
        else if (r_cnt == LAST) r_cnt <= '0;
        else                    r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/rc_pulse_gen.sv
// Multi-channel servo/ESC pulse generator: double-buffered widths/enables loaded at frame start,
// with a command watchdog that substitutes the neutral width while commands are absent.
module rc_pulse_gen
    import rc_pulse_gen_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int NCH        = 6,
    parameter int FRAME_US   = 20000,
    parameter int MIN_US     = 800,
    parameter int MAX_US     = 2200,
    parameter int NEUTRAL_US = 1500,
    parameter int WDT_US     = 500000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [23:0]    in_data,
    input  logic           in_wr,
    output logic [NCH-1:0] pwm,
    output logic           frame_stb,
    output logic           failsafe
);
    localparam int              FW         = cnt_w(FRAME_US);
    localparam int              WW         = cnt_w(WDT_US + 1);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAME_US - 1);
    localparam logic [WW-1:0]   WDT_TERM   = WW'(WDT_US);
    localparam logic [US_W-1:0] MIN_W      = US_W'(MIN_US);
    localparam logic [US_W-1:0] MAX_W      = US_W'(MAX_US);
    localparam logic [US_W-1:0] NEUTRAL_W  = US_W'(NEUTRAL_US);

    cmd_t           w_cmd;
    logic           w_tick;
    logic           w_frame_start;
    logic           w_is_width;
    logic           w_is_en;
    logic           w_cmd_ok;
    logic           w_unused_rsvd;

    logic [FW-1:0]  r_frame_cnt;
    logic           r_frame_stb;
    logic [NCH-1:0] r_sh_en;
    logic [NCH-1:0] r_act_en;
    logic [WW-1:0]  r_wdt;
    logic           r_failsafe;

    rc_pulse_gen_us_tick #(.CLK_DIV(CLK_DIV)) u_us_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    assign w_cmd         = cmd_t'(in_data);
    assign w_is_width    = in_wr && (int'(w_cmd.op) < NCH);
    assign w_is_en       = in_wr && (w_cmd.op == OP_ENABLE);
    assign w_cmd_ok      = w_is_width || w_is_en;
    assign w_unused_rsvd = ^w_cmd.rsvd;
    assign w_frame_start = w_tick && (r_frame_cnt == FRAME_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_frame_stb <= 1'b0;
            r_sh_en     <= '0;
            r_act_en    <= '0;
            r_wdt       <= '0;
            r_failsafe  <= 1'b0;
        end else begin
            r_frame_stb <= w_frame_start;
            if (w_tick)
                r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + 1'b1;
            if (w_is_en)
                r_sh_en <= in_data[NCH-1:0];
            // Active enable samples the pre-write shadow, so a coinciding write lands next frame.
            if (w_frame_start)
                r_act_en <= r_sh_en;
            if (w_cmd_ok) begin
                r_wdt      <= '0;
                r_failsafe <= 1'b0;
            end else if (w_tick && (r_wdt != WDT_TERM)) begin
                r_wdt <= r_wdt + 1'b1;
                if (r_wdt == WDT_TERM - 1'b1)
                    r_failsafe <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [US_W-1:0] r_sh_w;
        logic [US_W-1:0] r_act_w;
        logic            r_pwm;
        logic            w_wr_ch;

        assign w_wr_ch = w_is_width && (w_cmd.op == 4'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sh_w  <= '0;
                r_act_w <= '0;
                r_pwm   <= 1'b0;
            end else begin
                if (w_wr_ch)
                    r_sh_w <= clamp_us(w_cmd.arg, MIN_W, MAX_W);
                if (w_frame_start)
                    r_act_w <= r_failsafe ? NEUTRAL_W : r_sh_w;
                r_pwm <= r_act_en[gi] && (r_act_w != '0) && (32'(r_frame_cnt) < 32'(r_act_w));
            end
        end

        assign pwm[gi] = r_pwm;
    end

    assign frame_stb = r_frame_stb;
    assign failsafe  = r_failsafe;

endmodule

// File: tb/tb_rc_pulse_gen.sv
// Scoreboard bench for rc_pulse_gen: a cycle-count reference model queues expected frame
// pulse lengths and failsafe edges; a negedge monitor measures the DUT and compares.
module tb_rc_pulse_gen;

    localparam int CLK_DIV    = 4;
    localparam int NCH        = 6;
    localparam int FRAME_US   = 100;
    localparam int MIN_US     = 10;
    localparam int MAX_US     = 60;
    localparam int NEUTRAL_US = 30;
    localparam int WDT_US     = 300;
    localparam int FRAME_CLKS = FRAME_US * CLK_DIV;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic [23:0]    in_data = '0;
    logic           in_wr   = 1'b0;
    logic [NCH-1:0] pwm;
    logic           frame_stb;
    logic           failsafe;

    rc_pulse_gen #(
        .CLK_DIV(CLK_DIV), .NCH(NCH), .FRAME_US(FRAME_US), .MIN_US(MIN_US),
        .MAX_US(MAX_US), .NEUTRAL_US(NEUTRAL_US), .WDT_US(WDT_US)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_wr     (in_wr),
        .pwm       (pwm),
        .frame_stb (frame_stb),
        .failsafe  (failsafe)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: everything is derived from the edge count since reset release.
    int cyc;
    int cmd_cyc;
    bit fs_m;
    int sh_w   [NCH];
    int act_w  [NCH];
    bit sh_en  [NCH];
    bit act_en [NCH];
    int q_stb [$];
    int q_cnt [NCH][$];
    int q_fs_cyc [$];
    int q_fs_val [$];

    function automatic int clampw(input int v);
        if (v == 0)      return 0;
        if (v < MIN_US)  return MIN_US;
        if (v > MAX_US)  return MAX_US;
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            cyc     = 0;
            cmd_cyc = 0;
            fs_m    = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                sh_w[ch] = 0; act_w[ch] = 0; sh_en[ch] = 1'b0; act_en[ch] = 1'b0;
                q_cnt[ch].delete();
            end
            q_stb.delete();
            q_fs_cyc.delete();
            q_fs_val.delete();
        end else begin
            int op;
            bit new_fs;
            cyc++;
            if (cyc % FRAME_CLKS == 0) begin
                q_stb.push_back(cyc);
                for (int ch = 0; ch < NCH; ch++) begin
                    q_cnt[ch].push_back(act_en[ch] ? act_w[ch] * CLK_DIV : 0);
                    act_w[ch]  = fs_m ? NEUTRAL_US : sh_w[ch];
                    act_en[ch] = sh_en[ch];
                end
            end
            if (in_wr) begin
                op = int'(in_data[23:20]);
                if (op < NCH) begin
                    sh_w[op] = clampw(int'(in_data[11:0]));
                    cmd_cyc  = cyc;
                end else if (op == 15) begin
                    for (int ch = 0; ch < NCH; ch++) sh_en[ch] = in_data[ch];
                    cmd_cyc = cyc;
                end
            end
            new_fs = ((cyc / CLK_DIV) - (cmd_cyc / CLK_DIV)) >= WDT_US;
            if (new_fs != fs_m) begin
                q_fs_cyc.push_back(cyc);
                q_fs_val.push_back(int'(new_fs));
            end
            fs_m = new_fs;
        end
    end

    // Monitor: pulse clocks accumulated between frame strobes, plus failsafe edges.
    int acc [NCH];
    bit fs_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) acc[ch] = 0;
            fs_prev = 1'b0;
        end else begin
            if (frame_stb) begin
                if (q_stb.size() == 0) begin
                    chk("frame_stb_unexpected_at_cycle", cyc, -1);
                end else begin
                    chk("frame_stb_cycle", cyc, q_stb.pop_front());
                    for (int ch = 0; ch < NCH; ch++)
                        chk($sformatf("pwm%0d_high_clks", ch), acc[ch], q_cnt[ch].pop_front());
                    $display("frame cyc=%0d pwm_clks=%0d,%0d,%0d,%0d,%0d,%0d failsafe=%0d",
                             cyc, acc[0], acc[1], acc[2], acc[3], acc[4], acc[5], failsafe);
                end
                for (int ch = 0; ch < NCH; ch++) acc[ch] = 0;
            end
            for (int ch = 0; ch < NCH; ch++) acc[ch] += int'(pwm[ch]);
            if (failsafe != fs_prev) begin
                if (q_fs_cyc.size() == 0) begin
                    chk("failsafe_edge_unexpected_at_cycle", cyc, -1);
                end else begin
                    chk("failsafe_edge_cycle", cyc, q_fs_cyc.pop_front());
                    chk("failsafe_edge_level", int'(failsafe), q_fs_val.pop_front());
                end
                $display("failsafe cyc=%0d level=%0d", cyc, failsafe);
                fs_prev = failsafe;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int op, input int arg);
        @(negedge clk);
        in_wr   = 1'b1;
        in_data = {4'(op), 8'h00, 12'(arg)};
        @(negedge clk);
        in_wr   = 1'b0;
        in_data = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pwm"},       int'(pwm),       0);
        chk({tag, "_frame_stb"}, int'(frame_stb), 0);
        chk({tag, "_failsafe"},  int'(failsafe),  0);
    endtask

    initial begin
        bit hit;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        idle(450);

        // Basic: ch0 only, 25 us.
        wr(15, 6'h01);
        wr(0, 25);
        idle(1000);

        // Clamp on ch1: 5 -> MIN, 90 -> MAX, 0 -> silent.
        wr(15, 6'h03);
        wr(1, 5);
        idle(900);
        wr(1, 90);
        idle(900);
        wr(1, 0);
        idle(900);

        // Double buffer: rewrite ch0 while its pulse is high.
        wr(0, 25);
        idle(850);
        hit = 1'b0;
        for (int k = 0; k < 2 * FRAME_CLKS && !hit; k++) begin
            @(negedge clk);
            if (pwm[0]) hit = 1'b1;
        end
        chk("dbuf_wait_pwm0_high", int'(hit), 1);
        idle(10);
        wr(0, 50);
        idle(900);

        // Write landing exactly on the frame-start load edge.
        hit = 1'b0;
        for (int k = 0; k < 2 * FRAME_CLKS && !hit; k++) begin
            @(negedge clk);
            if (cyc % FRAME_CLKS == FRAME_CLKS - 1) hit = 1'b1;
        end
        chk("coincide_wait_frame_edge", int'(hit), 1);
        in_wr   = 1'b1;
        in_data = {4'h0, 8'h00, 12'd15};
        @(negedge clk);
        in_wr   = 1'b0;
        in_data = '0;
        idle(900);

        // Watchdog: silence (an ignored opcode does not kick it), neutral frames, recovery.
        idle(700);
        wr(9, 40);
        idle(1700);
        wr(15, 6'h03);
        idle(900);

        // Random commands, including ignored opcodes and out-of-range widths.
        repeat (40) begin
            int sel;
            int op;
            int arg;
            idle($urandom_range(1, 150));
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                op  = $urandom_range(0, NCH - 1);
                arg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 80);
            end else if (sel < 7) begin
                op  = 15;
                arg = $urandom_range(0, 63);
            end else begin
                op  = $urandom_range(NCH, 14);
                arg = $urandom_range(0, 4095);
            end
            wr(op, arg);
        end
        idle(900);

        // Asynchronous reset in the middle of a pulse.
        wr(15, 6'h01);
        wr(0, 40);
        hit = 1'b0;
        for (int k = 0; k < 3 * FRAME_CLKS && !hit; k++) begin
            @(negedge clk);
            if (pwm[0]) hit = 1'b1;
        end
        chk("reset_wait_pwm0_high", int'(hit), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(900);

        @(negedge clk);
        #1;
        chk("frames_left_unchecked", q_stb.size(), 0);
        chk("failsafe_edges_left_unchecked", q_fs_cyc.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
